// File: rtl/pulse_width_generator.sv
// Pulse train generator: emits cmd_count pulses of cmd_high active cycles separated
// by max(cmd_low,1) inactive cycles; cmd_count of 0 runs until abort.
module pulse_width_generator #(
  parameter int WIDTH       = 16,
  parameter int CNT_W       = 8,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_high,
  input  logic [WIDTH-1:0] cmd_low,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] high_cnt_q, high_cnt_d;
  logic [WIDTH-1:0] low_cnt_q, low_cnt_d;
  logic [WIDTH-1:0] high_len_q, low_len_q;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             cont_q, cont_d;
  logic             done_d;
  logic             accept;

  // A zero gap would merge consecutive pulses on the line, so it is raised to one cycle.
  function automatic logic [WIDTH-1:0] min_gap(input logic [WIDTH-1:0] low);
    return (low == '0) ? WIDTH'(1) : low;
  endfunction

  assign accept = (state_q == IDLE) && cmd_valid;

  always_comb begin
    state_d    = state_q;
    high_cnt_d = high_cnt_q;
    low_cnt_d  = low_cnt_q;
    rem_d      = rem_q;
    cont_d     = cont_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_high == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = PULSE;
            high_cnt_d = cmd_high;
            rem_d      = cmd_count;
            cont_d     = (cmd_count == '0);
          end
        end
      end
      PULSE: begin
        if (abort) begin
          state_d    = IDLE;
          high_cnt_d = '0;
          rem_d      = '0;
        end else begin
          high_cnt_d = high_cnt_q - WIDTH'(1);
          if (high_cnt_q == WIDTH'(1)) begin
            state_d   = GAP;
            low_cnt_d = low_len_q;
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_d   = IDLE;
          low_cnt_d = '0;
          rem_d     = '0;
        end else begin
          low_cnt_d = low_cnt_q - WIDTH'(1);
          if (low_cnt_q == WIDTH'(1)) begin
            if (cont_q) begin
              state_d    = PULSE;
              high_cnt_d = high_len_q;
            end else begin
              rem_d = rem_q - CNT_W'(1);
              if (rem_q == CNT_W'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end else begin
                state_d    = PULSE;
                high_cnt_d = high_len_q;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      high_cnt_q <= '0;
      low_cnt_q  <= '0;
      rem_q      <= '0;
      cont_q     <= 1'b0;
      pulse_out  <= ~ACTIVE_HIGH;
      busy       <= 1'b0;
      done       <= 1'b0;
      cmd_ready  <= 1'b1;
    end else begin
      state_q    <= state_d;
      high_cnt_q <= high_cnt_d;
      low_cnt_q  <= low_cnt_d;
      rem_q      <= rem_d;
      cont_q     <= cont_d;
      pulse_out  <= (state_d == PULSE) ? ACTIVE_HIGH : ~ACTIVE_HIGH;
      busy       <= (state_d != IDLE);
      done       <= done_d;
      cmd_ready  <= (state_d == IDLE);
    end
  end

  // Command capture; only read after a train has been started
  always_ff @(posedge clk) begin
    if (accept) begin
      high_len_q <= cmd_high;
      low_len_q  <= min_gap(cmd_low);
    end
  end

endmodule

// File: tb/tb_pulse_width_generator.sv
// Bench for pulse_width_generator: directed scenarios plus random command/abort/reset
// traffic, checked every cycle against an arithmetic model of the pulse train timing.
module tb_pulse_width_generator;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, abort;
  logic [15:0] cmd_high, cmd_low;
  logic [7:0]  cmd_count;
  logic        cmd_ready, pulse_out, busy, done;
  logic        cmd_ready_n, pulse_out_n, busy_n, done_n;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: the most recently accepted train, described by its acceptance cycle and fields
  bit have_train = 0;
  int t_acc, h_m, l_m, n_m;

  always #5 clk = ~clk;

  pulse_width_generator #(.WIDTH(16), .CNT_W(8), .ACTIVE_HIGH(1'b1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_high(cmd_high), .cmd_low(cmd_low), .cmd_count(cmd_count), .abort(abort),
    .pulse_out(pulse_out), .busy(busy), .done(done));

  pulse_width_generator #(.WIDTH(16), .CNT_W(8), .ACTIVE_HIGH(1'b0)) dut_n (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_n),
    .cmd_high(cmd_high), .cmd_low(cmd_low), .cmd_count(cmd_count), .abort(abort),
    .pulse_out(pulse_out_n), .busy(busy_n), .done(done_n));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected outputs in cycle c, derived from the train's start cycle and period
  function automatic void model_out(input int c, output logic p, output logic b,
                                    output logic d, output logic r);
    int per;
    p = 1'b0; b = 1'b0; d = 1'b0; r = 1'b1;
    if (have_train) begin
      if (h_m == 0) begin
        d = (c == t_acc + 1);
      end else begin
        per = h_m + l_m;
        if (c >= t_acc + 1 && (n_m == 0 || c <= t_acc + n_m * per)) begin
          b = 1'b1;
          r = 1'b0;
          p = ((c - t_acc - 1) % per) < h_m;
        end
        if (n_m != 0 && c == t_acc + n_m * per + 1) d = 1'b1;
      end
    end
  endfunction

  // Called mid-cycle: check this cycle's outputs, drive this cycle's inputs, advance one cycle
  task automatic step(input logic v, input logic [15:0] h, input logic [15:0] l,
                      input logic [7:0] n, input logic ab, input logic r, input bit chk);
    logic ep, eb, ed, er, epn;
    model_out(cyc, ep, eb, ed, er);
    epn = ~ep;
    if (chk) begin
      check_eq("pulse_out", pulse_out, ep);
      check_eq("busy", busy, eb);
      check_eq("done", done, ed);
      check_eq("cmd_ready", cmd_ready, er);
      check_eq("pulse_out_inverted", pulse_out_n, epn);
    end
    cmd_valid = v; cmd_high = h; cmd_low = l; cmd_count = n; abort = ab; rst = r;
    if (r) begin
      have_train = 0;
    end else begin
      if (ab && eb) have_train = 0;
      if (v && er) begin
        have_train = 1;
        t_acc = cyc;
        h_m = h;
        l_m = (l == 0) ? 1 : int'(l);
        n_m = n;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 16'($urandom), 16'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int hi, rl;
    logic [8:0] pat;
    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_high = '0; cmd_low = '0; cmd_count = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b0, 16'd0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    check_eq("reset_ready", cmd_ready, 1'b1);
    check_eq("reset_pulse", pulse_out, 1'b0);
    check_eq("reset_pulse_inv", pulse_out_n, 1'b1);
    idle();

    // Single pulse, width 5, gap 3
    step(1'b1, 16'd5, 16'd3, 8'd1, 1'b0, 1'b0, 1'b1);
    hi = 0; rl = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) check_eq("t1_first_pulse", pulse_out, 1'b1);
      hi += int'(pulse_out);
      rl += int'(!cmd_ready);
      idle();
    end
    check_eq("t1_high_cycles", hi, 5);
    check_eq("t1_ready_low_cycles", rl, 8);
    check_eq("t1_done_T9", done, 1'b1);
    idle();

    // Three pulses, width 2, zero gap raised to 1
    step(1'b1, 16'd2, 16'd0, 8'd3, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      pat[8-i] = pulse_out;
      idle();
    end
    check_eq("t2_pattern", pat, 9'b110110110);
    check_eq("t2_done_T10", done, 1'b1);
    idle();

    // Long pulse for an end-to-end width measurement
    step(1'b1, 16'd1000, 16'd4, 8'd1, 1'b0, 1'b0, 1'b1);
    hi = 0;
    for (int i = 0; i < 1004; i++) begin
      hi += int'(pulse_out);
      idle();
    end
    check_eq("t3_width_1000", hi, 1000);
    check_eq("t3_done", done, 1'b1);
    idle();

    // Continuous train aborted in the 3rd active cycle of pulse 2
    step(1'b1, 16'd4, 16'd4, 8'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) idle();
    check_eq("t4_pulse_before_abort", pulse_out, 1'b1);
    step(1'b0, 16'd0, 16'd0, 8'd0, 1'b1, 1'b0, 1'b1);
    check_eq("t4_abort_pulse", pulse_out, 1'b0);
    check_eq("t4_abort_no_done", done, 1'b0);
    check_eq("t4_abort_ready", cmd_ready, 1'b1);
    step(1'b1, 16'd3, 16'd1, 8'd1, 1'b0, 1'b0, 1'b1);
    check_eq("t4_new_cmd_pulse", pulse_out, 1'b1);
    for (int i = 0; i < 5; i++) idle();

    // Zero width: no pulse, done next cycle
    step(1'b1, 16'd0, 16'd3, 8'd7, 1'b0, 1'b0, 1'b1);
    check_eq("t5_zero_done", done, 1'b1);
    check_eq("t5_zero_pulse", pulse_out, 1'b0);
    check_eq("t5_zero_ready", cmd_ready, 1'b1);
    idle();
    check_eq("t5_done_one_cycle", done, 1'b0);

    // Reset mid-pulse with cmd_valid held high
    step(1'b1, 16'd100, 16'd2, 8'd1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) idle();
    step(1'b1, 16'd50, 16'd2, 8'd2, 1'b0, 1'b1, 1'b1);
    check_eq("t6_reset_pulse", pulse_out, 1'b0);
    check_eq("t6_reset_busy", busy, 1'b0);
    step(1'b1, 16'd50, 16'd2, 8'd2, 1'b1, 1'b1, 1'b1);
    step(1'b0, 16'd50, 16'd2, 8'd2, 1'b0, 1'b0, 1'b1);
    check_eq("t6_no_accept_in_reset", busy, 1'b0);
    idle();

    // Back-to-back command in the done cycle
    step(1'b1, 16'd3, 16'd2, 8'd2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) idle();
    check_eq("t7_done", done, 1'b1);
    step(1'b1, 16'd2, 16'd1, 8'd1, 1'b0, 1'b0, 1'b1);
    check_eq("t7_b2b_pulse", pulse_out, 1'b1);
    for (int i = 0; i < 4; i++) idle();

    // Random traffic; inputs keep changing after acceptance
    for (int i = 0; i < 3000; i++) begin
      logic v, ab, r;
      v  = ($urandom_range(0, 2) == 0);
      ab = ($urandom_range(0, 49) == 0) ||
           (have_train && n_m == 0 && h_m != 0 && (cyc - t_acc) > 60);
      r  = ($urandom_range(0, 299) == 0);
      step(v, 16'($urandom_range(0, 6)), 16'($urandom_range(0, 4)),
           8'($urandom_range(0, 4)), ab, r, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_width_generator.md
# pulse_width_generator

Transmit-side counterpart of the pulse width counter: it produces pulses of commanded high width and low gap, in whole clock cycles, for a commanded number of repetitions. It sits in the tt_um top next to the pulse width counter. It drives a dedicated output (or loops back into the counter input), so a commanded width can be measured end to end. Commands arrive over a valid/ready handshake; completion is reported by a one-cycle `done` strobe.

## Interface
- `WIDTH`, 16: bit width of the high and low cycle counts.
- `CNT_W`, 8: bit width of the repetition count.
- `ACTIVE_HIGH`, 1: 1 means the pulse is driven high on an idle-low line; 0 inverts `pulse_out`.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  generator idle and able to accept a command.
- `cmd_high`  in  WIDTH  pulse active width in cycles.
- `cmd_low`  in  WIDTH  inactive gap after each pulse in cycles.
- `cmd_count`  in  CNT_W  number of pulses; 0 means continuous until abort.
- `abort`  in  1  stop the current train.
- `pulse_out`  out  1  generated pulse (registered).
- `busy`  out  1  train in progress.
- `done`  out  1  one-cycle strobe when a train completes normally.

## Operation
- States: IDLE, PULSE, GAP.
- IDLE:
  - `cmd_ready` = 1 and `busy` = 0.
  - The command is accepted on a rising edge where `cmd_valid & cmd_ready`.
  - All three command fields are captured into internal registers on acceptance; later input changes have no effect.
- Acceptance with `cmd_high` = 0:
  - No pulse is produced, and the block stays in IDLE.
  - `done` pulses one cycle later, regardless of `cmd_count`.
- Acceptance otherwise:
  - Go to PULSE, load the high counter with `cmd_high`, and load the remaining-pulse counter with `cmd_count`.
- PULSE:
  - `pulse_out` is active.
  - The high counter decrements each cycle.
  - On the last cycle, go to GAP and load the low counter with max(`cmd_low`, 1).
  - The minimum gap of 1 keeps repeated pulses distinguishable by the counter.
- GAP:
  - `pulse_out` is inactive.
  - On the last cycle, decrement the remaining count (skipped in continuous mode).
  - If the count is now 0, go to IDLE and assert `done` together with `cmd_ready`.
  - Otherwise, go back to PULSE with the high counter reloaded.
- Abort:
  - `abort` sampled high in PULSE or GAP: next cycle `pulse_out` is inactive, state is IDLE, `busy` = 0 and `cmd_ready` = 1.
  - `done` is not asserted on abort.
  - `abort` in IDLE is ignored.
- Commands while busy: `cmd_valid` is ignored; nothing is queued.
- Arithmetic: counters are WIDTH/CNT_W unsigned and never wrap. The maximum width is 2^WIDTH−1 cycles, so `cmd_high` = all-ones gives 65535 active cycles at the default width.
- Reset:
  - Applies in any state, including mid-pulse.
  - Next cycle: `pulse_out` inactive, `busy` 0, `done` 0, `cmd_ready` 1, all counters 0.
  - `cmd_valid` and `abort` are ignored while `rst` is high.
- Output polarity: inactive = ~`ACTIVE_HIGH`, active = `ACTIVE_HIGH`.

## Timing
- The command is accepted at edge T (end of cycle T).
- `pulse_out` is active in cycles T+1 … T+H, then inactive in T+H+1 … T+H+L, where L = max(`cmd_low`, 1).
- Pulse k (0-based) starts at cycle T+1+k·(H+L).
- For N pulses:
  - `done` = 1 and `cmd_ready` = 1 in cycle T+N·(H+L)+1.
  - A new command may be accepted in that same cycle; its first pulse then starts the following cycle.
- `busy` = 1 from T+1 through T+N·(H+L) inclusive.
- Latencies: `abort` sampled in cycle A gives IDLE outputs at A+1; `rst` has the same one-cycle latency.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then `cmd_high`=5, `cmd_low`=3, `cmd_count`=1 → `pulse_out` high exactly 5 cycles starting T+1; `done` at T+9; `cmd_ready` low T+1..T+8.
- `cmd_high`=2, `cmd_low`=0, `cmd_count`=3 → pattern 110110110 from T+1; `done` at T+10.
- Loopback into the pulse width counter, `cmd_high`=1000, `cmd_count`=1 → counter reports 1000.
- `cmd_count`=0, `cmd_high`=4, `cmd_low`=4, abort asserted in the 3rd PULSE cycle of pulse 2 → `pulse_out` low next cycle, no `done`, `cmd_ready`=1; then a new command is accepted.
- `cmd_high`=0, `cmd_count`=7 → no pulse; `done` at T+1.
- `rst` high mid-PULSE with `cmd_high`=100 → next cycle all outputs at reset values; `cmd_valid` held high during reset is not accepted. Also: back-to-back command accepted in the `done` cycle starts its pulse the next cycle; `ACTIVE_HIGH`=0 gives an inverted waveform.
